// File: rtl/pipeline_hazard_unit.sv
// Hazard detection and forwarding control for the 5-stage pipeline.
// Shadows the destinations held in ID/EX (E) and EX/MEM (M) to drive stall, flush and EX operand selects.
module pipeline_hazard_unit #(
    parameter int ADDR_W = 5,
    parameter int FWD_EN = 1,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              id_valid,
    input  logic [ADDR_W-1:0] id_rs,
    input  logic [ADDR_W-1:0] id_rt,
    input  logic              id_uses_rs,
    input  logic              id_uses_rt,
    input  logic [ADDR_W-1:0] id_dest,
    input  logic              id_reg_write,
    input  logic              id_mem_read,
    input  logic              ex_redirect,
    output logic              stall,
    output logic              flush_if_id,
    output logic              flush_id_ex,
    output logic [1:0]        fwd_a_sel,
    output logic [1:0]        fwd_b_sel,
    output logic [CNT_W-1:0]  stall_count,
    output logic [CNT_W-1:0]  flush_count
);

    localparam bit FWD = (FWD_EN != 0);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic              e_v;
    logic              e_wr;
    logic              e_ld;
    logic [ADDR_W-1:0] e_dest;
    // M never needs the load flag: a load in MEM is already forwardable from WB.
    logic              m_v;
    logic              m_wr;
    logic [ADDR_W-1:0] m_dest;

    logic e_live;
    logic m_live;
    logic x_a;
    logic x_b;
    logic m_a;
    logic m_b;
    logic hazard;
    logic bubble;
    logic [1:0] fa_next;
    logic [1:0] fb_next;

    assign e_live = e_v & e_wr & (e_dest != '0);
    assign m_live = m_v & m_wr & (m_dest != '0);

    assign x_a = id_valid & id_uses_rs & e_live & (e_dest == id_rs);
    assign x_b = id_valid & id_uses_rt & e_live & (e_dest == id_rt);
    assign m_a = id_valid & id_uses_rs & m_live & (m_dest == id_rs);
    assign m_b = id_valid & id_uses_rt & m_live & (m_dest == id_rt);

    always_comb begin
        hazard = 1'b0;
        if (FWD) begin
            hazard = id_valid & e_ld & (x_a | x_b);
        end else begin
            hazard = x_a | x_b | m_a | m_b;
        end
    end

    // Redirect wins over stall; everything is quiet while in reset.
    assign stall       = ~reset & ~ex_redirect & hazard;
    assign flush_if_id = ~reset & ex_redirect;
    assign flush_id_ex = ~reset & ex_redirect;

    assign bubble = stall | ex_redirect | ~id_valid;

    always_comb begin
        fa_next = 2'd0;
        fb_next = 2'd0;
        if (FWD && !bubble) begin
            if (x_a) begin
                fa_next = 2'd1;
            end else if (m_a) begin
                fa_next = 2'd2;
            end
            if (x_b) begin
                fb_next = 2'd1;
            end else if (m_b) begin
                fb_next = 2'd2;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            e_v         <= 1'b0;
            e_wr        <= 1'b0;
            e_ld        <= 1'b0;
            e_dest      <= '0;
            m_v         <= 1'b0;
            m_wr        <= 1'b0;
            m_dest      <= '0;
            fwd_a_sel   <= 2'd0;
            fwd_b_sel   <= 2'd0;
            stall_count <= '0;
            flush_count <= '0;
        end else begin
            m_v    <= e_v;
            m_wr   <= e_wr;
            m_dest <= e_dest;
            if (bubble) begin
                e_v    <= 1'b0;
                e_wr   <= 1'b0;
                e_ld   <= 1'b0;
                e_dest <= '0;
            end else begin
                e_v    <= 1'b1;
                e_wr   <= id_reg_write;
                e_ld   <= id_mem_read;
                e_dest <= id_dest;
            end
            fwd_a_sel <= fa_next;
            fwd_b_sel <= fb_next;
            if (stall && stall_count != CNT_MAX) begin
                stall_count <= stall_count + CNT_ONE;
            end
            if (ex_redirect && flush_count != CNT_MAX) begin
                flush_count <= flush_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_pipeline_hazard_unit.sv
// Scoreboard bench for pipeline_hazard_unit: a forwarding instance (default
// parameters) and a stall-only instance with 2-bit counters share one stimulus.
module tb_pipeline_hazard_unit;

    logic       clk = 1'b0;
    logic       reset;
    logic       id_valid;
    logic [4:0] id_rs;
    logic [4:0] id_rt;
    logic       id_uses_rs;
    logic       id_uses_rt;
    logic [4:0] id_dest;
    logic       id_reg_write;
    logic       id_mem_read;
    logic       ex_redirect;

    logic        stall, flush_if_id, flush_id_ex;
    logic [1:0]  fwd_a_sel, fwd_b_sel;
    logic [15:0] stall_count, flush_count;

    logic        stall_s, flush_if_id_s, flush_id_ex_s;
    logic [1:0]  fwd_a_sel_s, fwd_b_sel_s;
    logic [1:0]  stall_count_s, flush_count_s;

    int n_cmp = 0;
    int n_err = 0;

    typedef struct packed {
        logic       v;
        logic [4:0] rs;
        logic [4:0] rt;
        logic       urs;
        logic       urt;
        logic [4:0] dest;
        logic       rw;
        logic       ld;
        logic       redir;
        logic       ex_stall;
        logic [1:0] ex_fa;
        logic [1:0] ex_fb;
    } step_t;

    step_t exp_q[$];

    pipeline_hazard_unit dut (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
        .stall(stall), .flush_if_id(flush_if_id), .flush_id_ex(flush_id_ex),
        .fwd_a_sel(fwd_a_sel), .fwd_b_sel(fwd_b_sel),
        .stall_count(stall_count), .flush_count(flush_count)
    );

    pipeline_hazard_unit #(.ADDR_W(5), .FWD_EN(0), .CNT_W(2)) dut_s (
        .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
        .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_dest(id_dest),
        .id_reg_write(id_reg_write), .id_mem_read(id_mem_read), .ex_redirect(ex_redirect),
        .stall(stall_s), .flush_if_id(flush_if_id_s), .flush_id_ex(flush_id_ex_s),
        .fwd_a_sel(fwd_a_sel_s), .fwd_b_sel(fwd_b_sel_s),
        .stall_count(stall_count_s), .flush_count(flush_count_s)
    );

    always #5 clk = ~clk;

    function automatic step_t st(input int v, input int rs, input int rt, input int urs,
                                 input int urt, input int dest, input int rw, input int ld,
                                 input int redir, input int x_stall, input int x_fa,
                                 input int x_fb);
        step_t s;
        s.v        = v[0];
        s.rs       = rs[4:0];
        s.rt       = rt[4:0];
        s.urs      = urs[0];
        s.urt      = urt[0];
        s.dest     = dest[4:0];
        s.rw       = rw[0];
        s.ld       = ld[0];
        s.redir    = redir[0];
        s.ex_stall = x_stall[0];
        s.ex_fa    = x_fa[1:0];
        s.ex_fb    = x_fb[1:0];
        return s;
    endfunction

    function automatic step_t idle();
        return st(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    task automatic set_inputs(input step_t s);
        id_valid     = s.v;
        id_rs        = s.rs;
        id_rt        = s.rt;
        id_uses_rs   = s.urs;
        id_uses_rt   = s.urt;
        id_dest      = s.dest;
        id_reg_write = s.rw;
        id_mem_read  = s.ld;
        ex_redirect  = s.redir;
    endtask

    task automatic drive(input step_t s);
        set_inputs(s);
        exp_q.push_back(s);
    endtask

    task automatic do_reset();
        set_inputs(idle());
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        exp_q.delete();
    endtask

    task automatic test_reset();
        reset = 1'b1;
        set_inputs(st(1, 8, 8, 1, 1, 8, 1, 1, 1, 0, 0, 0));
        @(posedge clk); #1;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL reset_stall got %b want 0", stall); end
        n_cmp++; if (flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin n_err++; $display("FAIL reset_flush got %b%b want 00", flush_if_id, flush_id_ex); end
        n_cmp++; if (fwd_a_sel !== 2'd0 || fwd_b_sel !== 2'd0) begin n_err++; $display("FAIL reset_fwd got %0d/%0d want 0/0", fwd_a_sel, fwd_b_sel); end
        n_cmp++; if (fwd_a_sel_s !== 2'd0 || fwd_b_sel_s !== 2'd0 || stall_s !== 1'b0) begin n_err++; $display("FAIL reset_s got %0d/%0d/%b want 0/0/0", fwd_a_sel_s, fwd_b_sel_s, stall_s); end
        @(posedge clk); #1;
        n_cmp++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin n_err++; $display("FAIL reset_counts got %0d/%0d want 0/0", stall_count, flush_count); end
        n_cmp++; if (stall_count_s !== 2'd0 || flush_count_s !== 2'd0) begin n_err++; $display("FAIL reset_counts_s got %0d/%0d want 0/0", stall_count_s, flush_count_s); end
        reset = 1'b0;
        set_inputs(idle());
    endtask

    // Runs a sequence on the forwarding instance, one instruction per cycle.
    task automatic test_fwd_seq(input string name, input step_t seq[$],
                                input int want_stalls, input int want_flushes);
        step_t e;
        logic  o_stall, o_f1, o_f2;
        do_reset();
        foreach (seq[i]) begin
            drive(seq[i]);
            @(negedge clk);
            o_stall = stall;
            o_f1    = flush_if_id;
            o_f2    = flush_id_ex;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (o_stall !== e.ex_stall) begin n_err++; $display("FAIL %s[%0d] stall got %b want %b", name, i, o_stall, e.ex_stall); end
            n_cmp++; if (o_f1 !== e.redir || o_f2 !== e.redir) begin n_err++; $display("FAIL %s[%0d] flush got %b%b want %b", name, i, o_f1, o_f2, e.redir); end
            n_cmp++; if (fwd_a_sel !== e.ex_fa) begin n_err++; $display("FAIL %s[%0d] fwd_a got %0d want %0d", name, i, fwd_a_sel, e.ex_fa); end
            n_cmp++; if (fwd_b_sel !== e.ex_fb) begin n_err++; $display("FAIL %s[%0d] fwd_b got %0d want %0d", name, i, fwd_b_sel, e.ex_fb); end
        end
        n_cmp++; if (stall_count !== want_stalls[15:0]) begin n_err++; $display("FAIL %s stall_count got %0d want %0d", name, stall_count, want_stalls); end
        n_cmp++; if (flush_count !== want_flushes[15:0]) begin n_err++; $display("FAIL %s flush_count got %0d want %0d", name, flush_count, want_flushes); end
    endtask

    task automatic test_fwd_ex();
        step_t seq[$];
        seq.push_back(st(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 0));  // add $8,$1,$2
        seq.push_back(st(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 1, 1));  // add $9,$8,$8
        seq.push_back(idle());
        test_fwd_seq("fwd_ex", seq, 0, 0);
    endtask

    task automatic test_fwd_mem();
        step_t seq[$];
        seq.push_back(st(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 0));   // add $8
        seq.push_back(st(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));   // nop
        seq.push_back(st(1, 0, 8, 1, 1, 10, 1, 0, 0, 0, 0, 2));  // sub $10,$0,$8
        seq.push_back(idle());
        test_fwd_seq("fwd_mem", seq, 0, 0);
    endtask

    task automatic test_load_use();
        step_t seq[$];
        seq.push_back(st(1, 1, 8, 1, 0, 8, 1, 1, 0, 0, 0, 0));  // lw $8,0($1)
        seq.push_back(st(1, 8, 1, 1, 1, 9, 1, 0, 0, 1, 0, 0));  // add $9,$8,$1 stalled
        seq.push_back(st(1, 8, 1, 1, 1, 9, 1, 0, 0, 0, 2, 0));  // re-issued
        seq.push_back(idle());
        test_fwd_seq("load_use", seq, 1, 0);
    endtask

    task automatic test_reg_zero();
        step_t seq[$];
        seq.push_back(st(1, 1, 2, 1, 1, 0, 1, 0, 0, 0, 0, 0));   // writes $0
        seq.push_back(st(1, 0, 0, 1, 1, 9, 1, 0, 0, 0, 0, 0));   // reads $0,$0
        seq.push_back(st(1, 1, 2, 1, 1, 8, 0, 1, 0, 0, 0, 0));   // dest $8, no write
        seq.push_back(st(1, 8, 8, 1, 1, 10, 1, 0, 0, 0, 0, 0));
        seq.push_back(st(1, 8, 8, 1, 1, 11, 1, 0, 0, 0, 0, 0));
        seq.push_back(idle());
        test_fwd_seq("reg_zero", seq, 0, 0);
    endtask

    task automatic test_priority();
        step_t seq[$];
        seq.push_back(st(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 0));
        seq.push_back(st(1, 3, 4, 1, 1, 9, 1, 0, 0, 0, 0, 0));
        seq.push_back(st(1, 8, 9, 1, 1, 10, 1, 0, 0, 0, 2, 1));
        seq.push_back(st(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 0));
        seq.push_back(st(1, 3, 4, 1, 1, 8, 1, 0, 0, 0, 0, 0));
        seq.push_back(st(1, 8, 8, 1, 1, 12, 1, 0, 0, 0, 1, 1));  // youngest $8 wins
        seq.push_back(idle());
        test_fwd_seq("priority", seq, 0, 0);
    endtask

    task automatic test_redirect();
        step_t seq[$];
        seq.push_back(st(1, 1, 8, 1, 0, 8, 1, 1, 0, 0, 0, 0));  // lw $8
        seq.push_back(st(1, 8, 1, 1, 1, 9, 1, 0, 1, 0, 0, 0));  // dependent + redirect
        seq.push_back(idle());
        test_fwd_seq("redirect", seq, 0, 1);
    endtask

    // Stall-only instance: each dependent add waits two cycles; 2-bit counter saturates.
    task automatic test_stall_only();
        step_t seq[$];
        step_t e;
        logic  o_stall;
        int    chk_at[3];
        int    chk_val[3];
        int    k;
        chk_at  = '{3, 6, 9};
        chk_val = '{2, 3, 3};
        do_reset();
        seq.push_back(st(1, 1, 2, 1, 1, 8, 1, 0, 0, 0, 0, 0));
        seq.push_back(st(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 0, 0));
        seq.push_back(st(1, 8, 8, 1, 1, 9, 1, 0, 0, 1, 0, 0));
        seq.push_back(st(1, 8, 8, 1, 1, 9, 1, 0, 0, 0, 0, 0));
        seq.push_back(st(1, 9, 9, 1, 1, 10, 1, 0, 0, 1, 0, 0));
        seq.push_back(st(1, 9, 9, 1, 1, 10, 1, 0, 0, 1, 0, 0));
        seq.push_back(st(1, 9, 9, 1, 1, 10, 1, 0, 0, 0, 0, 0));
        seq.push_back(st(1, 10, 10, 1, 1, 11, 1, 0, 0, 1, 0, 0));
        seq.push_back(st(1, 10, 10, 1, 1, 11, 1, 0, 0, 1, 0, 0));
        seq.push_back(st(1, 10, 10, 1, 1, 11, 1, 0, 0, 0, 0, 0));
        k = 0;
        foreach (seq[i]) begin
            drive(seq[i]);
            @(negedge clk);
            o_stall = stall_s;
            @(posedge clk); #1;
            e = exp_q.pop_front();
            n_cmp++; if (o_stall !== e.ex_stall) begin n_err++; $display("FAIL stall_only[%0d] stall got %b want %b", i, o_stall, e.ex_stall); end
            n_cmp++; if (fwd_a_sel_s !== e.ex_fa || fwd_b_sel_s !== e.ex_fb) begin n_err++; $display("FAIL stall_only[%0d] fwd got %0d/%0d want %0d/%0d", i, fwd_a_sel_s, fwd_b_sel_s, e.ex_fa, e.ex_fb); end
            if (k < 3 && i == chk_at[k]) begin
                n_cmp++; if (stall_count_s !== chk_val[k][1:0]) begin n_err++; $display("FAIL stall_only[%0d] stall_count got %0d want %0d", i, stall_count_s, chk_val[k]); end
                k++;
            end
        end
        set_inputs(idle());
    endtask

    task automatic test_reset_mid_run();
        step_t e;
        logic  o_stall;
        do_reset();
        drive(st(1, 1, 8, 1, 0, 8, 1, 1, 0, 0, 0, 0));
        @(posedge clk); #1;
        void'(exp_q.pop_front());
        drive(st(1, 8, 1, 1, 1, 9, 1, 0, 0, 1, 0, 0));
        @(negedge clk);
        o_stall = stall;
        n_cmp++; if (o_stall !== 1'b1) begin n_err++; $display("FAIL mid_reset pre_stall got %b want 1", o_stall); end
        #1;
        reset       = 1'b1;
        ex_redirect = 1'b1;
        #1;
        n_cmp++; if (stall !== 1'b0 || flush_if_id !== 1'b0 || flush_id_ex !== 1'b0) begin n_err++; $display("FAIL mid_reset gate got %b%b%b want 000", stall, flush_if_id, flush_id_ex); end
        @(posedge clk); #1;
        e = exp_q.pop_front();
        n_cmp++; if (fwd_a_sel !== e.ex_fa || fwd_b_sel !== e.ex_fb) begin n_err++; $display("FAIL mid_reset fwd got %0d/%0d want %0d/%0d", fwd_a_sel, fwd_b_sel, e.ex_fa, e.ex_fb); end
        n_cmp++; if (stall_count !== 16'd0 || flush_count !== 16'd0) begin n_err++; $display("FAIL mid_reset counts got %0d/%0d want 0/0", stall_count, flush_count); end
        reset       = 1'b0;
        ex_redirect = 1'b0;
        #3;
        n_cmp++; if (stall !== 1'b0) begin n_err++; $display("FAIL mid_reset post_stall got %b want 0", stall); end
        @(posedge clk); #1;
        set_inputs(idle());
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_fwd_ex();
        test_fwd_mem();
        test_load_use();
        test_reg_zero();
        test_priority();
        test_redirect();
        test_stall_only();
        test_reset_mid_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
